// File: rtl/cram_loader_pkg.sv
// Shared types and constants for the CRAM loader.
// The VERIFY state exists only when CRAM_READBACK_EN is defined.
package cram_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
`ifdef CRAM_READBACK_EN
      ST_VERIFY = 2'd2,
`endif
      ST_DONE   = 2'd3
   } state_e;

   localparam logic [7:0] CRC_POLY = 8'h07;
   localparam logic [7:0] CRC_INIT = 8'h00;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (MSB-first feedback), cleared by rst or clr, advanced by en.
module crc8_serial
   import cram_loader_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [7:0] crc
);

   logic [7:0] crc_q;
   logic       fb;

   assign fb = crc_q[7] ^ bit_in;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         crc_q <= CRC_INIT;
      end else if (en) begin
         crc_q <= {crc_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/cram_loader.sv
// Serial CRAM chain loader: host words are shifted LSB first into the chain.
// Optional readback verify (recirculating CRC compare) under CRAM_READBACK_EN.
module cram_loader
   import cram_loader_pkg::*;
#(
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned CHAIN_LEN = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              word_valid,
   input  logic [WORD_W-1:0] word_data,
   output logic              word_ready,
   output logic              config_data_in,
   output logic              config_en,
   input  logic              config_data_out,
   output logic              fabric_en,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int unsigned SB_W  = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
   localparam logic [SB_W-1:0]  WORD_W_C    = SB_W'(WORD_W);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] sbuf_q, sbuf_d;
   logic [SB_W-1:0]   sbits_q, sbits_d;
   logic              error_q, error_d;
   logic              shifting, accept, in_verify, vshift;

   assign shifting = (state_q == ST_LOAD) && (sbits_q != '0);
   // Ready on an empty buffer or on the last-bit cycle, as long as unbuffered bits remain.
   assign word_ready = (state_q == ST_LOAD) && (sbits_q <= SB_W'(1))
                       && (cnt_q > CNT_W'(sbits_q));
   assign accept = word_valid && word_ready;

`ifdef CRAM_READBACK_EN
   logic [7:0] crc_load, crc_rb;

   assign in_verify      = (state_q == ST_VERIFY);
   assign vshift         = in_verify && (cnt_q != '0);
   assign config_data_in = in_verify ? config_data_out : (shifting & sbuf_q[0]);

   crc8_serial u_crc_load (
      .clk    (clk),
      .rst    (rst),
      .clr    (start && !busy),
      .en     (shifting),
      .bit_in (sbuf_q[0]),
      .crc    (crc_load)
   );

   crc8_serial u_crc_rb (
      .clk    (clk),
      .rst    (rst),
      .clr    (start && !busy),
      .en     (vshift),
      .bit_in (config_data_out),
      .crc    (crc_rb)
   );
`else
   logic unused_cdo;

   assign in_verify      = 1'b0;
   assign vshift         = 1'b0;
   assign config_data_in = shifting & sbuf_q[0];
   assign unused_cdo     = config_data_out;
`endif

   assign config_en = shifting || vshift;
   assign busy      = (state_q == ST_LOAD) || in_verify;
   assign done      = (state_q == ST_DONE);
   assign fabric_en = (state_q == ST_DONE);
   assign error     = error_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sbuf_d  = sbuf_q;
      sbits_d = sbits_q;
      error_d = error_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_LOAD;
               cnt_d   = CHAIN_LEN_C;
               sbuf_d  = '0;
               sbits_d = '0;
               error_d = 1'b0;
            end
         end
         ST_LOAD: begin
            // A new word overrides the shift; its predecessor's last bit leaves this cycle.
            if (accept) begin
               sbuf_d  = word_data;
               sbits_d = WORD_W_C;
            end else if (shifting) begin
               sbuf_d  = sbuf_q >> 1;
               sbits_d = sbits_q - SB_W'(1);
            end
            if (shifting) begin
               cnt_d = cnt_q - CNT_W'(1);
            end
            if (cnt_q == '0) begin
`ifdef CRAM_READBACK_EN
               state_d = ST_VERIFY;
               cnt_d   = CHAIN_LEN_C;
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef CRAM_READBACK_EN
         ST_VERIFY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = ST_DONE;
               error_d = (crc_load != crc_rb);
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sbuf_q  <= '0;
         sbits_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sbuf_q  <= sbuf_d;
         sbits_q <= sbits_d;
         error_q <= error_d;
      end
   end

endmodule

// File: tb/tb_cram_loader.sv
// Directed bench for cram_loader (WORD_W=8, CHAIN_LEN=16) with a 16-bit chain model.
// Readback cases are compiled in when CRAM_READBACK_EN is defined.
module tb_cram_loader;

`ifdef CRAM_READBACK_EN
   localparam int EXP_TOTAL = 32;
`else
   localparam int EXP_TOTAL = 16;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       word_valid = 1'b0;
   logic [7:0] word_data = 8'h00;
   logic       word_ready, config_data_in, config_en, config_data_out;
   logic       fabric_en, busy, done, error;

   logic [15:0] chain = 16'h0000;
   logic [15:0] stuck_mask = 16'h0000;

   int checks = 0;
   int errors = 0;

   // Per-load observations
   int          ntotal, gaps, fab_bad, ready_late;
   logic [15:0] bits;
   logic        got_done, aborted;

   always #5 clk = ~clk;

   cram_loader #(
      .WORD_W    (8),
      .CHAIN_LEN (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .word_valid      (word_valid),
      .word_data       (word_data),
      .word_ready      (word_ready),
      .config_data_in  (config_data_in),
      .config_en       (config_en),
      .config_data_out (config_data_out),
      .fabric_en       (fabric_en),
      .busy            (busy),
      .done            (done),
      .error           (error)
   );

   // Chain: head at config_data_in, tail at chain[0]; masked bits are stuck at 0.
   always @(posedge clk) begin
      if (config_en) chain <= {config_data_in, chain[15:1]} & ~stuck_mask;
   end
   assign config_data_out = chain[0];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts a load and services the host side; samples at negedges.
   task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input int stall,
                           input int start_at, input int rst_at);
      int idx = 0;
      int stall_left = stall;
      logic start_pulsed = 1'b0;
      ntotal = 0; gaps = 0; fab_bad = 0; ready_late = 0;
      bits = 16'h0000; got_done = 1'b0; aborted = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (fabric_en) fab_bad++;
         if (word_ready && ntotal >= 16) ready_late++;
         if (config_en) begin
            if (ntotal < 16) bits[ntotal] = config_data_in;
            ntotal++;
         end else if (ntotal > 0 && ntotal < 16) begin
            gaps++;
         end
         start = 1'b0;
         if (start_at >= 0 && !start_pulsed && ntotal == start_at) begin
            start = 1'b1;
            start_pulsed = 1'b1;
         end
         if (rst_at >= 0 && ntotal == rst_at) begin
            rst = 1'b1;
            word_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            aborted = 1'b1;
            break;
         end
         if (word_ready && idx == 1 && stall_left > 0) begin
            word_valid = 1'b0;
            stall_left--;
         end else if (idx < 2) begin
            word_valid = 1'b1;
            word_data = (idx == 0) ? w0 : w1;
            if (word_ready) idx++;
         end else begin
            word_valid = 1'b0;
         end
         @(negedge clk);
      end
      word_valid = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_word_ready", word_ready, 0);
      chk("rst_config_en", config_en, 0);
      chk("rst_config_data_in", config_data_in, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_fabric_en", fabric_en, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_hold_busy", busy, 0);

      // Basic load: A5 then 3C streamed with no stalls
      run_load(8'hA5, 8'h3C, 0, -1, -1);
      chk("basic_done_seen", got_done, 1);
      chk("basic_shifts", ntotal, EXP_TOTAL);
      chk("basic_bits", bits, 16'h3CA5);
      chk("basic_gaps", gaps, 0);
      chk("basic_fabric_low", fab_bad, 0);
      chk("basic_ready_after", ready_late, 0);
      chk("basic_done", done, 1);
      chk("basic_fabric_en", fabric_en, 1);
      chk("basic_error", error, 0);
      chk("basic_chain", chain, 16'h3CA5);
      @(negedge clk);
      chk("done_hold", done, 1);

      // Host stall of 3 cycles between the words, started from DONE
      run_load(8'hA5, 8'h3C, 3, -1, -1);
      chk("stall_done_seen", got_done, 1);
      chk("stall_gaps", gaps, 3);
      chk("stall_bits", bits, 16'h3CA5);
      chk("stall_shifts", ntotal, EXP_TOTAL);
      chk("stall_fabric_low", fab_bad, 0);

      // start pulsed mid-load is ignored
      run_load(8'h5A, 8'hC3, 0, 4, -1);
      chk("sbusy_done_seen", got_done, 1);
      chk("sbusy_shifts", ntotal, EXP_TOTAL);
      chk("sbusy_bits", bits, 16'hC35A);
      chk("sbusy_chain", chain, 16'hC35A);

      // Reset after 5 shifted bits, then a clean reload
      run_load(8'hA5, 8'h3C, 0, -1, 5);
      chk("rmid_aborted", aborted, 1);
      chk("rmid_busy", busy, 0);
      chk("rmid_config_en", config_en, 0);
      chk("rmid_word_ready", word_ready, 0);
      chk("rmid_done", done, 0);
      chk("rmid_fabric_en", fabric_en, 0);
      @(negedge clk);
      chk("rmid_quiet_en", config_en, 0);
      run_load(8'hA5, 8'h3C, 0, -1, -1);
      chk("rmid_reload_done", got_done, 1);
      chk("rmid_reload_bits", bits, 16'h3CA5);
      chk("rmid_reload_shifts", ntotal, EXP_TOTAL);

`ifdef CRAM_READBACK_EN
      // Readback fault: chain bit 4 stuck at 0 under all-ones data
      stuck_mask = 16'h0010;
      run_load(8'hFF, 8'hFF, 0, -1, -1);
      chk("fault_done_seen", got_done, 1);
      chk("fault_done", done, 1);
      chk("fault_error", error, 1);
      stuck_mask = 16'h0000;
      run_load(8'hA5, 8'h3C, 0, -1, -1);
      chk("clean_error", error, 0);
      chk("clean_chain", chain, 16'h3CA5);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
